// File: rtl/secure_memory_pkg.sv
// Shared op codes, FSM states and default key
// for the secure memory custom instruction.
package secure_memory_pkg;

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_KEYLD = 3'd2;

  localparam logic [31:0] DEFAULT_KEY = 32'h95DA4EAB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_XOR,
    S_WR_XOR,
    S_WR_REQ,
    S_DONE
  } state_t;

endpackage

// File: rtl/secure_memory_cipher.sv
// XOR cipher shared by the read and write paths;
// optionally tweaks the key with the word offset.
module secure_memory_cipher #(
  parameter int DATA_W   = 32,
  parameter int KEY_MODE = 0,
  parameter int OFF_W    = 14
) (
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] key,
  input  logic [OFF_W-1:0]  word_off,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] eff_key;

  always_comb begin
    eff_key = key;
    if (KEY_MODE == 1)
      eff_key = key ^ DATA_W'(word_off);
    dout = data ^ eff_key;
  end

endmodule

// File: rtl/secure_memory_ctrl.sv
// Nios II custom-instruction slave that XOR-encrypts
// accesses to an on-chip RAM window over Avalon-MM.
module secure_memory_ctrl
  import secure_memory_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(16'h8000),
  parameter int DEPTH    = 8192,
  parameter logic [DATA_W-1:0] XOR_KEY = DATA_W'(DEFAULT_KEY),
  parameter int KEY_MODE = 0,
  parameter int MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   dataa,
  input  logic [31:0]         datab,
  input  logic [2:0]          n,
  input  logic                clk_en,
  input  logic                start,
  output logic                done,
  output logic [DATA_W-1:0]   result,
  output logic                err,
  output logic [ADDR_W-3:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W-1:0]   readdata,
  input  logic                waitrequest
);

  localparam int OFF_W = ADDR_W - 2;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  state_t            state_q;
  logic [2:0]        op_q;
  logic [OFF_W-1:0]  off_q;
  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] xored;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] off;
  logic              bad;
  logic              is_rw;
  logic              bus;
  logic              unused_hi;

  assign addr      = datab[ADDR_W-1:0];
  assign off       = addr - BASE_ADDR;
  assign unused_hi = ^datab[31:ADDR_W];
  assign is_rw     = (n == OP_READ) || (n == OP_WRITE);

  // no wrap: below-base addresses are errors, not aliases
  assign bad = (addr[1:0] != 2'b00)
            || (addr < BASE_ADDR)
            || (32'(off) >= 32'(4 * DEPTH));

  secure_memory_cipher #(
    .DATA_W  (DATA_W),
    .KEY_MODE(KEY_MODE),
    .OFF_W   (OFF_W)
  ) u_cipher (
    .data    (buf_q),
    .key     (key_q),
    .word_off(off_q),
    .dout    (xored)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      off_q   <= '0;
      buf_q   <= '0;
      key_q   <= XOR_KEY;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (clk_en) begin
      unique case (state_q)
        S_IDLE: if (start) begin
          op_q  <= n;
          off_q <= off[ADDR_W-1:2];
          buf_q <= '0;
          cnt_q <= '0;
          if (is_rw && bad) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (n == OP_READ) begin
            state_q <= S_RD_REQ;
          end else if (n == OP_WRITE) begin
            buf_q   <= dataa;
            state_q <= S_WR_XOR;
          end else begin
            if (n == OP_KEYLD) begin
              key_q <= dataa;
              err_q <= 1'b0;
            end
            state_q <= S_DONE;
          end
        end
        S_RD_REQ, S_WR_REQ: begin
          if (!waitrequest) begin
            if (state_q == S_RD_REQ) begin
              buf_q   <= readdata;
              state_q <= S_RD_XOR;
            end else begin
              state_q <= S_DONE;
            end
          end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            err_q   <= 1'b1;
            buf_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RD_XOR: begin
          buf_q   <= xored;
          state_q <= S_DONE;
        end
        S_WR_XOR: begin
          buf_q   <= xored;
          state_q <= S_WR_REQ;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus        = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign chipselect = bus;
  assign read       = (state_q == S_RD_REQ);
  assign write      = (state_q == S_WR_REQ);
  assign byteenable = bus ? '1 : '0;
  assign address    = bus ? off_q : '0;
  assign writedata  = write ? buf_q : '0;
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

  // writes and failed reads leave buf_q non-result data
  assign result = (done && op_q == OP_READ) ? buf_q : '0;

endmodule

// File: tb/tb_secure_memory_ctrl.sv
// Directed vector bench: u0 static key, u1 offset-tweaked
// key, both with a 1K-word window and MAX_WAIT=4.
module tb_secure_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic        waitrequest = 1'b0;
  logic [2:0]  n = '0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic [31:0] readdata = '0;

  logic [1:0]  done, err, cs, rd, wr;
  logic [31:0] res [2];
  logic [31:0] wd [2];
  logic [13:0] ad [2];
  logic [3:0]  be [2];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] K0 = 32'h95DA4EAB;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
    int          st;
    int          lat;
    logic [31:0] res;
    logic [31:0] res1;
    logic [31:0] wd;
    logic [31:0] wd1;
    logic [13:0] ad;
    logic        e;
    int          sc;
  } vec_t;

  vec_t v [15];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    secure_memory_ctrl #(
      .DEPTH   (1024),
      .KEY_MODE(g),
      .MAX_WAIT(4)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .dataa      (dataa),
      .datab      (datab),
      .n          (n),
      .clk_en     (clk_en),
      .start      (start),
      .done       (done[g]),
      .result     (res[g]),
      .err        (err[g]),
      .address    (ad[g]),
      .byteenable (be[g]),
      .chipselect (cs[g]),
      .read       (rd[g]),
      .write      (wr[g]),
      .writedata  (wd[g]),
      .readdata   (readdata),
      .waitrequest(waitrequest)
    );
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input vec_t t, input int id);
    int left, lat, sc;
    logic got;
    logic [31:0] r0, r1, w0, w1;
    logic [13:0] a0;
    logic e;
    r0 = '0; r1 = '0; w0 = '0; w1 = '0;
    a0 = '0; e = 1'b0; got = 1'b0;
    left = t.st; lat = 0; sc = 0;
    @(negedge clk);
    n = t.op; dataa = t.a; datab = t.b;
    readdata = t.rd; start = 1'b1;
    waitrequest = 1'b0;
    @(posedge clk);
    while (!got && lat < 40) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (cs[0]) begin
        sc++;
        a0 = ad[0];
        w0 = wd[0];
        w1 = wd[1];
        waitrequest = (left > 0);
        if (left > 0) left--;
      end else begin
        waitrequest = 1'b0;
      end
      if (done[0]) begin
        got = 1'b1;
        r0 = res[0];
        r1 = res[1];
        e = err[0];
      end
    end
    waitrequest = 1'b0;
    chk($sformatf("v%0d.lat", id), 64'(lat), 64'(t.lat));
    chk($sformatf("v%0d.res", id), 64'(r0), 64'(t.res));
    chk($sformatf("v%0d.res1", id), 64'(r1), 64'(t.res1));
    chk($sformatf("v%0d.err", id), 64'(e), 64'(t.e));
    chk($sformatf("v%0d.wd", id), 64'(w0), 64'(t.wd));
    chk($sformatf("v%0d.wd1", id), 64'(w1), 64'(t.wd1));
    chk($sformatf("v%0d.addr", id), 64'(a0), 64'(t.ad));
    chk($sformatf("v%0d.busy", id), 64'(sc), 64'(t.sc));
  endtask

  function automatic logic [63:0] outs(input int i);
    return {done[i], err[i], cs[i], rd[i], wr[i],
            be[i], ad[i], 10'b0} ^ {res[i], wd[i]};
  endfunction

  initial begin
    vec_t t;
    int cnt;

    v[0]  = '{3'd1, 32'h12345678, 32'h8010, 32'h0, 0,
              3, 32'h0, 32'h0, 32'h87EE18D3, 32'h87EE18D7,
              14'h4, 1'b0, 1};
    v[1]  = '{3'd0, 32'h0, 32'h8010, 32'h87EE18D3, 3,
              6, 32'h12345678, 32'h1234567C, 32'h0, 32'h0,
              14'h4, 1'b0, 4};
    v[2]  = '{3'd5, 32'h0, 32'h8000, 32'h0, 0,
              1, 32'h0, 32'h0, 32'h0, 32'h0, 14'h0, 1'b0, 0};
    v[3]  = '{3'd0, 32'h0, 32'h7FFC, 32'h0, 0,
              1, 32'h0, 32'h0, 32'h0, 32'h0, 14'h0, 1'b1, 0};
    v[4]  = '{3'd1, 32'h1, 32'h8002, 32'h0, 0,
              1, 32'h0, 32'h0, 32'h0, 32'h0, 14'h0, 1'b1, 0};
    v[5]  = '{3'd0, 32'h0, 32'h9000, 32'h0, 0,
              1, 32'h0, 32'h0, 32'h0, 32'h0, 14'h0, 1'b1, 0};
    v[6]  = '{3'd0, 32'h0, 32'h8000, 32'h0, 0,
              3, K0, K0, 32'h0, 32'h0, 14'h0, 1'b1, 1};
    v[7]  = '{3'd2, 32'h0, 32'h8000, 32'h0, 0,
              1, 32'h0, 32'h0, 32'h0, 32'h0, 14'h0, 1'b0, 0};
    v[8]  = '{3'd1, 32'hA5A5A5A5, 32'h8010, 32'h0, 0,
              3, 32'h0, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A1,
              14'h4, 1'b0, 1};
    v[9]  = '{3'd0, 32'h0, 32'h8010, 32'hA5A5A5A1, 0,
              3, 32'hA5A5A5A1, 32'hA5A5A5A5, 32'h0, 32'h0,
              14'h4, 1'b0, 1};
    v[10] = '{3'd1, 32'h0F0F0F0F, 32'h18010, 32'h0, 0,
              3, 32'h0, 32'h0, 32'h0F0F0F0F, 32'h0F0F0F0B,
              14'h4, 1'b0, 1};
    v[11] = '{3'd0, 32'h0, 32'h8FFC, 32'h0, 0,
              3, 32'h0, 32'h3FF, 32'h0, 32'h0,
              14'h3FF, 1'b0, 1};
    v[12] = '{3'd0, 32'h0, 32'h8000, 32'h0, 100,
              5, 32'h0, 32'h0, 32'h0, 32'h0, 14'h0, 1'b1, 4};
    v[13] = '{3'd2, K0, 32'h8000, 32'h0, 0,
              1, 32'h0, 32'h0, 32'h0, 32'h0, 14'h0, 1'b0, 0};
    v[14] = '{3'd1, 32'h12345678, 32'h8000, 32'h0, 100,
              6, 32'h0, 32'h0, 32'h87EE18D3, 32'h87EE18D3,
              14'h0, 1'b1, 4};

    repeat (2) @(negedge clk);
    chk("reset.u0", outs(0), 64'h0);
    chk("reset.u1", outs(1), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) do_op(v[i], i);

    // abort a write in WR_REQ with a non-default key loaded
    t = '{3'd2, 32'h11111111, 32'h8000, 32'h0, 0,
          1, 32'h0, 32'h0, 32'h0, 32'h0, 14'h0, 1'b0, 0};
    do_op(t, 15);
    @(negedge clk);
    n = 3'd1; dataa = 32'h0; datab = 32'h8010;
    start = 1'b1; waitrequest = 1'b0;
    cnt = 0;
    while (!wr[0] && cnt < 10) begin
      @(negedge clk);
      start = 1'b0;
      cnt++;
    end
    chk("rst.wr_seen", 64'(wr[0]), 64'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst.u0", outs(0), 64'h0);
    chk("rst.u1", outs(1), 64'h0);
    @(negedge clk);
    chk("rst.nodone", 64'(done), 64'h0);
    reset = 1'b0;

    t = '{3'd0, 32'h0, 32'h8000, 32'h0, 0,
          3, K0, K0, 32'h0, 32'h0, 14'h0, 1'b0, 1};
    do_op(t, 16);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/secure_memory_ctrl.md
Name: secure_memory_ctrl

Overview:
Parametrised successor to the XOR-encrypting secure memory custom instruction. It is a Nios II custom-instruction slave that encrypts writes and decrypts reads to an on-chip RAM window through an Avalon-MM master. Compared with the previous generation it adds:
- a true FSM that honours waitrequest
- a runtime-loadable key with an optional address-tweaked key mode
- window and alignment checking
- a bus timeout and a sticky error flag

Parameters:
DATA_W, 32, data/key width (multiple of 8)
ADDR_W, 16, byte-address width taken from datab
BASE_ADDR, 16'h8000, byte base of secure window
DEPTH, 8192, window size in words
XOR_KEY, 32'h95DA4EAB, key value after reset
KEY_MODE, 0, 0 = static key; 1 = effective key is key XOR zero-extended word offset
MAX_WAIT, 255, maximum waitrequest cycles before timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
dataa  in  DATA_W  write data (n=1) / new key (n=2)
datab  in  32  byte address; bits [ADDR_W-1:0] used
n  in  3  op: 0 read, 1 write, 2 key load, 3-7 no-op
clk_en  in  1  custom-instruction clock enable
start  in  1  op start, sampled in IDLE
done  out  1  one-cycle completion pulse
result  out  DATA_W  decrypted read data, else 0
err  out  1  sticky: bad address or timeout; cleared by reset or any key load
address  out  ADDR_W-2  word address = (datab - BASE_ADDR) >> 2
byteenable  out  DATA_W/8  all ones during access, else 0
chipselect  out  1  bus access active
read  out  1  read strobe
write  out  1  write strobe
writedata  out  DATA_W  encrypted data during write, else 0
readdata  in  DATA_W  memory read data, valid in the accept cycle
waitrequest  in  1  slave stall

Behaviour:
- Reset, synchronous: state=IDLE, key=XOR_KEY, err=0, wait counter=0. All outputs are 0.
- Bus outputs are 0 whenever the FSM is not in RD_REQ or WR_REQ. result is 0 except in the DONE cycle.
- clk_en=0 freezes the FSM, counters and registers. Bus outputs hold their current values.
- States: IDLE, RD_REQ, RD_XOR, WR_XOR, WR_REQ, DONE.
- IDLE with start=1 and clk_en=1 latches n, dataa and the computed offset, then branches:
  - bad address → DONE with err=1, no bus cycle. Bad means datab[1:0]!=0, datab<BASE_ADDR, or offset>=4*DEPTH.
  - n=0 → RD_REQ
  - n=1 → WR_XOR
  - n=2 → key<=dataa, err<=0, → DONE
  - n=3..7 → DONE, result 0
- RD_REQ: chipselect=read=1. The accept cycle is the first cycle with waitrequest=0. In that cycle readdata is captured and the FSM moves to RD_XOR. RD_XOR registers captured XOR eff_key, then → DONE.
- WR_XOR: registers dataa XOR eff_key, then → WR_REQ. WR_REQ: chipselect=write=1 and writedata=the registered value. On the accept cycle → DONE.
- Timeout: in RD_REQ/WR_REQ the wait counter increments each stalled cycle. If MAX_WAIT stalled cycles elapse with no accept, strobes drop, err<=1, result=0 and the FSM → DONE.
- DONE: done=1 for one cycle, then → IDLE. start is ignored while not in IDLE.
- Latency from start cycle T with zero wait states:
  - read: done at T+3
  - write: done at T+3
  - key load, no-op or bad address: done at T+1
  - each stall cycle adds one.
- Width and wrap rules:
  - offset is computed modulo 2^ADDR_W, with no wrap into the window. An address below BASE_ADDR is an error, not an alias.
  - In KEY_MODE=1 the key is tweaked with the word offset zero-extended to DATA_W.
- Reset mid-operation aborts immediately: strobes drop next edge, no done is issued, and the key returns to XOR_KEY.

Decomposition:
- Package secure_memory_pkg holds: the op-code constants (OP_READ=0, OP_WRITE=1, OP_KEYLD=2), the FSM state enum, and the default key constant.
- One sub-module, secure_memory_cipher: a combinational data XOR eff_key, parametrised by DATA_W and KEY_MODE, with the key and word offset as inputs. Both the read and write paths use it.

Test Plan:
- Write: n=1, dataa=0x12345678, datab=0x8010, no stalls → at T+2 address=4, write=1, writedata=0x87EE18D3, byteenable=4'hF; done at T+3.
- Read: n=0, datab=0x8010, readdata=0x87EE18D3, waitrequest high for 3 cycles → read held 4 cycles; done at T+6 with result=0x12345678.
- Error: datab=0x7FFC, then datab=0x8002 → no chipselect, done at T+1, result 0, err=1; a following key load clears err.
- Key load and KEY_MODE=1: n=2, dataa=0; then write dataa=0xA5A5A5A5 to datab=0x8010 → writedata=0xA5A5A5A1.
- Timeout: waitrequest stuck high with MAX_WAIT=4 → strobes drop after 4 stall cycles, done pulses, err=1, result 0.
- Reset asserted in WR_REQ → next edge all bus outputs 0, no done; after release a read of 0x8000 works and uses the key 0x95DA4EAB.
